cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- System-control coprocessor register file that sits directly upstream of the exception controller.
- Holds Count, Compare, Status, Cause, EPC and PRId, and generates the timer interrupt.
- Classifies the current instruction's exception request into the excptype code and supplies the EPC value the controller consumes.
- Serves mtc0/mfc0 accesses from the execute/writeback stage.

Parameters:
- PRID_VAL, 32'h0001_8000, read-only PRId (reg 15) value.
- TICK_DIV, 1, Count increments once every TICK_DIV clocks (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_valid  in  1  instruction in this stage is valid and not squashed
- pc_i  in  32  PC of the instruction in this stage
- syscall_req  in  1  instruction is SYSCALL
- eret_req  in  1  instruction is ERET
- cp0_we  in  1  mtc0 write enable
- cp0_waddr  in  5  mtc0 register number
- cp0_wdata  in  32  mtc0 data
- cp0_raddr  in  5  mfc0 register number
- cp0_rdata  out  32  mfc0 data (combinational)
- excptype  out  32  exception code to controller (combinational)
- epc  out  32  EPC value to controller (combinational)
- timer_int  out  1  Cause.IP7 pending flag
- status_o  out  32  Status register
- cause_o  out  32  Cause register

Behaviour:
- Reset: rst, synchronous, active-high. Count=0, Compare=0, Status=0, Cause=0, EPC=0, divider=0, timer_int=0. excptype=0 and cp0_rdata=0 while rst=1.
- Register map:
  - 9 Count (RW).
  - 11 Compare (RW).
  - 12 Status: bit0 IE, bit1 EXL, bits15:8 IM; other bits read 0, writes ignored.
  - 13 Cause: bit15 IP7, bits6:2 ExcCode; software-writable bits are none, writes ignored.
  - 14 EPC (RW).
  - 15 PRId (RO).
  - Any other address reads 0 and ignores writes.
- Count: the divider counts 0..TICK_DIV-1. When it wraps, Count increments mod 2^32. Count wraps from FFFF_FFFF to 0.
- Timer set: on the cycle Count==Compare and Compare!=0, IP7 is set next edge (sticky).
- Timer clear: a write to Compare clears IP7. Clear wins over a same-cycle set.
- excptype, combinational, evaluated only when inst_valid=1; otherwise 0. Priority highest first:
  - 32'h0000_0004 if IE=1 & EXL=0 & IM[7]=1 & IP7=1.
  - 32'h0000_0100 if syscall_req.
  - 32'h0000_0200 if eret_req.
  - else 32'h0000_0000.
- Exception entry, on the edge, for timer or syscall:
  - EXL <= 1.
  - ExcCode <= 0 (timer) or 8 (syscall).
  - EPC <= pc_i (timer: instruction is re-executed) or pc_i+4 (syscall).
- Eret, on the edge: EXL <= 0. EPC is unchanged.
- epc output = current EPC register. With the optional feature enabled, a same-cycle mtc0 to EPC is forwarded.
- Squash: when excptype != 0, the same-cycle mtc0 write is discarded (the instruction does not commit).
- mtc0 to Count loads cp0_wdata. The increment is suppressed that edge and the divider is reset to 0.
- A write to Status sets EXL directly. Software may clear EXL via mtc0.
- Simultaneous syscall_req and eret_req: syscall wins per priority. Eret has no effect.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of a pending interrupt or an in-flight write.

Optional Feature:
- Macro: CP0_RD_BYPASS_EN.
- Defined: if cp0_we=1 and cp0_waddr==cp0_raddr (a writable address) and the write is not squashed, cp0_rdata returns the field-masked cp0_wdata. The epc output likewise forwards a same-cycle EPC write.
- Undefined: cp0_rdata and epc always return register contents (new value visible the cycle after the write).

Test Plan:
- Reset, then mfc0 of regs 9/11/12/13/14 -> all 0; reg 15 -> PRID_VAL; reg 3 -> 0.
- TICK_DIV=1; mtc0 Compare=10; Status=32'h0000_8001; hold inst_valid=1, pc_i=32'h100:
  - Count reaches 10 -> IP7 set next cycle.
  - excptype=32'h4 -> at that edge EPC=32'h100, EXL=1, ExcCode=0.
  - excptype returns to 0 while EXL=1.
- syscall_req=1, inst_valid=1, pc_i=32'h200 -> excptype=32'h100; next cycle EPC=32'h204, EXL=1, ExcCode=8. Then eret_req=1 -> excptype=32'h200, epc=32'h204; next cycle EXL=0.
- Same cycle: syscall_req=1 and mtc0 EPC=32'hDEAD -> mtc0 discarded, EPC=pc_i+4. Separately, inst_valid=0 with syscall_req=1 -> excptype=0, no state change.
- IP7 pending plus mtc0 Compare=20 -> IP7 cleared. mtc0 Count=32'hFFFF_FFFF -> next cycle FFFF_FFFF, following cycle 0. TICK_DIV=4 -> Count steps every 4 clocks.
- CP0_RD_BYPASS_EN defined: mtc0 EPC=32'h300 with raddr=14 -> cp0_rdata=32'h300 the same cycle. Undefined: old value that cycle, 32'h300 the next cycle.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile: Count/Compare/Status/Cause/EPC/PRId, timer interrupt, excptype.
// Optional `CP0_RD_BYPASS_EN forwards same-cycle mtc0 data to cp0_rdata/epc.
module cp0_regfile #(
   parameter logic [31:0] PRID_VAL = 32'h0001_8000,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid,
   input  logic [31:0] pc_i,
   input  logic        syscall_req,
   input  logic        eret_req,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   output logic [31:0] excptype,
   output logic [31:0] epc,
   output logic        timer_int,
   output logic [31:0] status_o,
   output logic [31:0] cause_o
);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;
   localparam logic [4:0] A_PRID    = 5'd15;
   localparam logic [7:0] DIV_LAST  = 8'(TICK_DIV - 1);

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic [31:0] epc_q;
   logic [7:0]  div_q;
   logic [7:0]  im_q;
   logic [4:0]  exccode_q;
   logic        ie_q;
   logic        exl_q;
   logic        ip7_q;

   logic        timer_exc;
   logic        sys_exc;
   logic        eret_exc;
   logic        commit;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_epc;
   logic        tick;
   logic        timer_hit;
   logic [31:0] rd_reg;

   assign status_o  = {16'h0, im_q, 6'h0, exl_q, ie_q};
   assign cause_o   = {16'h0, ip7_q, 8'h0, exccode_q, 2'b00};
   assign timer_int = ip7_q;

   always_comb begin
      timer_exc = 1'b0;
      sys_exc   = 1'b0;
      eret_exc  = 1'b0;
      if (!rst && inst_valid) begin
         if (ie_q && !exl_q && im_q[7] && ip7_q)
            timer_exc = 1'b1;
         else if (syscall_req)
            sys_exc = 1'b1;
         else if (eret_req)
            eret_exc = 1'b1;
      end
   end

   always_comb begin
      excptype = 32'h0;
      unique case (1'b1)
         timer_exc: excptype = 32'h0000_0004;
         sys_exc:   excptype = 32'h0000_0100;
         eret_exc:  excptype = 32'h0000_0200;
         default:   excptype = 32'h0;
      endcase
   end

   // An excepting instruction does not commit its mtc0.
   assign commit     = !rst && cp0_we && (excptype == 32'h0);
   assign wr_count   = commit && (cp0_waddr == A_COUNT);
   assign wr_compare = commit && (cp0_waddr == A_COMPARE);
   assign wr_status  = commit && (cp0_waddr == A_STATUS);
   assign wr_epc     = commit && (cp0_waddr == A_EPC);
   assign tick       = (div_q == DIV_LAST);
   assign timer_hit  = (count_q == compare_q) && (compare_q != 32'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
         epc_q     <= 32'h0;
         div_q     <= 8'h0;
         im_q      <= 8'h0;
         exccode_q <= 5'h0;
         ie_q      <= 1'b0;
         exl_q     <= 1'b0;
         ip7_q     <= 1'b0;
      end else begin
         if (wr_count) begin
            count_q <= cp0_wdata;
            div_q   <= 8'h0;
         end else if (tick) begin
            count_q <= count_q + 32'd1;
            div_q   <= 8'h0;
         end else begin
            div_q <= div_q + 8'd1;
         end

         if (wr_compare)
            compare_q <= cp0_wdata;

         // Compare write acknowledges the timer and beats a same-cycle match.
         if (wr_compare)
            ip7_q <= 1'b0;
         else if (timer_hit)
            ip7_q <= 1'b1;

         if (wr_status) begin
            ie_q  <= cp0_wdata[0];
            exl_q <= cp0_wdata[1];
            im_q  <= cp0_wdata[15:8];
         end

         if (wr_epc)
            epc_q <= cp0_wdata;

         if (timer_exc) begin
            exl_q     <= 1'b1;
            exccode_q <= 5'd0;
            epc_q     <= pc_i;
         end else if (sys_exc) begin
            exl_q     <= 1'b1;
            exccode_q <= 5'd8;
            epc_q     <= pc_i + 32'd4;
         end else if (eret_exc) begin
            exl_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_reg = 32'h0;
      case (cp0_raddr)
         A_COUNT:   rd_reg = count_q;
         A_COMPARE: rd_reg = compare_q;
         A_STATUS:  rd_reg = status_o;
         A_CAUSE:   rd_reg = cause_o;
         A_EPC:     rd_reg = epc_q;
         A_PRID:    rd_reg = PRID_VAL;
         default:   rd_reg = 32'h0;
      endcase
   end

`ifdef CP0_RD_BYPASS_EN
   logic        fwd_hit;
   logic        waddr_rw;
   logic [31:0] wmask;

   always_comb begin
      waddr_rw = (cp0_waddr == A_COUNT) || (cp0_waddr == A_COMPARE) ||
                 (cp0_waddr == A_STATUS) || (cp0_waddr == A_EPC);
      wmask    = (cp0_waddr == A_STATUS) ? 32'h0000_FF03 : 32'hFFFF_FFFF;
      fwd_hit  = commit && waddr_rw && (cp0_waddr == cp0_raddr);
   end

   assign cp0_rdata = rst ? 32'h0 :
                      fwd_hit ? (cp0_wdata & wmask) : rd_reg;
   assign epc       = wr_epc ? cp0_wdata : epc_q;
`else
   assign cp0_rdata = rst ? 32'h0 : rd_reg;
   assign epc       = epc_q;
`endif

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios plus random traffic
// against a register-level reference model.
module tb_cp0_regfile;

   localparam logic [31:0] PRID = 32'h0001_8000;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] pc_i;
   logic        syscall_req;
   logic        eret_req;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata, excptype, epc, status_o, cause_o;
   logic        timer_int;
   logic [31:0] r4_rdata, r4_excptype, r4_epc, r4_status, r4_cause;
   logic        r4_timer;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cp0_regfile #(.PRID_VAL(PRID), .TICK_DIV(1)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_i(pc_i),
      .syscall_req(syscall_req), .eret_req(eret_req), .cp0_we(cp0_we),
      .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
      .cp0_rdata(cp0_rdata), .excptype(excptype), .epc(epc),
      .timer_int(timer_int), .status_o(status_o), .cause_o(cause_o));

   cp0_regfile #(.PRID_VAL(PRID), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_i(pc_i),
      .syscall_req(syscall_req), .eret_req(eret_req), .cp0_we(cp0_we),
      .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
      .cp0_rdata(r4_rdata), .excptype(r4_excptype), .epc(r4_epc),
      .timer_int(r4_timer), .status_o(r4_status), .cause_o(r4_cause));

   // Reference model of the architectural state (TICK_DIV = 1 instance).
   logic [31:0] m_count, m_cmp, m_epc;
   logic [7:0]  m_im;
   logic [4:0]  m_code;
   logic        m_ie, m_exl, m_ip7;

   function automatic logic [31:0] m_exc();
      if (rst || !inst_valid) return 32'h0;
      if (m_ie && !m_exl && m_im[7] && m_ip7) return 32'h4;
      if (syscall_req) return 32'h100;
      if (eret_req) return 32'h200;
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_status();
      return {16'h0, m_im, 6'h0, m_exl, m_ie};
   endfunction

   function automatic logic [31:0] m_cause();
      return {16'h0, m_ip7, 8'h0, m_code, 2'b00};
   endfunction

   function automatic bit m_fwd(input logic [4:0] a);
`ifdef CP0_RD_BYPASS_EN
      if (rst || !cp0_we || m_exc() != 32'h0 || cp0_waddr != a) return 1'b0;
      return (a == 5'd9) || (a == 5'd11) || (a == 5'd12) || (a == 5'd14);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] m_rdata();
      if (rst) return 32'h0;
      if (m_fwd(cp0_raddr))
         return (cp0_raddr == 5'd12) ? (cp0_wdata & 32'h0000_FF03) : cp0_wdata;
      case (cp0_raddr)
         5'd9:    return m_count;
         5'd11:   return m_cmp;
         5'd12:   return m_status();
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_epc_out();
      return m_fwd(5'd14) ? cp0_wdata : m_epc;
   endfunction

   task automatic drive(input logic iv, input logic [31:0] pc,
                        input logic sys, input logic er, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra);
      inst_valid  = iv;
      pc_i        = pc;
      syscall_req = sys;
      eret_req    = er;
      cp0_we      = we;
      cp0_waddr   = wa;
      cp0_wdata   = wd;
      cp0_raddr   = ra;
      #1;
   endtask

   // Advance one clock edge, updating the model from the pre-edge inputs.
   task automatic step();
      logic [31:0] e, n_count, n_cmp, n_epc;
      logic [7:0]  n_im;
      logic [4:0]  n_code;
      logic        n_ie, n_exl, n_ip7, wr;
      e = m_exc();
      wr = cp0_we && (e == 32'h0);
      n_count = m_count; n_cmp = m_cmp; n_epc = m_epc; n_im = m_im;
      n_code = m_code; n_ie = m_ie; n_exl = m_exl; n_ip7 = m_ip7;
      if (rst) begin
         n_count = 0; n_cmp = 0; n_epc = 0; n_im = 0;
         n_code = 0; n_ie = 0; n_exl = 0; n_ip7 = 0;
      end else begin
         n_count = (wr && cp0_waddr == 5'd9) ? cp0_wdata : m_count + 32'd1;
         if (wr && cp0_waddr == 5'd11) begin
            n_cmp = cp0_wdata;
            n_ip7 = 1'b0;
         end else if (m_count == m_cmp && m_cmp != 0) begin
            n_ip7 = 1'b1;
         end
         if (wr && cp0_waddr == 5'd12) begin
            n_ie = cp0_wdata[0]; n_exl = cp0_wdata[1]; n_im = cp0_wdata[15:8];
         end
         if (wr && cp0_waddr == 5'd14) n_epc = cp0_wdata;
         if (e == 32'h4) begin
            n_exl = 1; n_code = 0; n_epc = pc_i;
         end else if (e == 32'h100) begin
            n_exl = 1; n_code = 8; n_epc = pc_i + 32'd4;
         end else if (e == 32'h200) begin
            n_exl = 0;
         end
      end
      @(posedge clk);
      m_count = n_count; m_cmp = n_cmp; m_epc = n_epc; m_im = n_im;
      m_code = n_code; m_ie = n_ie; m_exl = n_exl; m_ip7 = n_ip7;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [4:0] ra [5];
      ra = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      rst = 1'b1;
      drive(1, 32'h80, 1, 0, 1, 5'd14, 32'h1234, 5'd15);
      step();
      step();
      checks++;
      if (excptype !== 32'h0) begin
         errors++;
         $display("FAIL rst_excptype: got %h want 0", excptype);
      end
      checks++;
      if (cp0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_rdata: got %h want 0", cp0_rdata);
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 5'd9);
      checks++;
      if (cp0_rdata !== 32'h0 || timer_int !== 1'b0) begin
         errors++;
         $display("FAIL rst_count: got %h/%b want 0/0", cp0_rdata, timer_int);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 5'd15);
      checks++;
      if (cp0_rdata !== PRID) begin
         errors++;
         $display("FAIL rst_prid: got %h want %h", cp0_rdata, PRID);
      end
      foreach (ra[i]) begin
         step();
         drive(0, 0, 0, 0, 0, 0, 0, ra[i]);
         checks++;
         if (cp0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_reg%0d: got %h want 0", ra[i], cp0_rdata);
         end
      end
   endtask

   task automatic test_timer();
      bit found = 0;
      drive(0, 0, 0, 0, 1, 5'd9, 32'h0, 5'd9);
      step();
      drive(0, 0, 0, 0, 1, 5'd11, 32'd10, 5'd9);
      step();
      drive(0, 0, 0, 0, 1, 5'd12, 32'h0000_8001, 5'd9);
      step();
      for (int i = 0; i < 30; i++) begin
         drive(1, 32'h100, 0, 0, 0, 0, 0, 5'd9);
         if (cp0_rdata == 32'd10) begin
            found = 1;
            break;
         end
         step();
      end
      checks++;
      if (!found || timer_int !== 1'b0) begin
         errors++;
         $display("FAIL timer_reach: found=%b ip7=%b want 1/0", found, timer_int);
      end
      step();
      checks++;
      if (timer_int !== 1'b1 || excptype !== 32'h4) begin
         errors++;
         $display("FAIL timer_set: ip7=%b exc=%h want 1/4", timer_int, excptype);
      end
      step();
      checks++;
      if (epc !== 32'h100 || status_o[1] !== 1'b1 || cause_o[6:2] !== 5'd0) begin
         errors++;
         $display("FAIL timer_entry: epc=%h exl=%b code=%0d want 100/1/0",
                  epc, status_o[1], cause_o[6:2]);
      end
      checks++;
      if (excptype !== 32'h0 || timer_int !== 1'b1) begin
         errors++;
         $display("FAIL timer_masked: exc=%h ip7=%b want 0/1", excptype, timer_int);
      end
   endtask

   task automatic test_syscall_eret();
      drive(1, 32'h200, 1, 0, 0, 0, 0, 5'd14);
      checks++;
      if (excptype !== 32'h100) begin
         errors++;
         $display("FAIL sys_exc: got %h want 100", excptype);
      end
      step();
      checks++;
      if (epc !== 32'h204 || status_o[1] !== 1'b1 || cause_o[6:2] !== 5'd8) begin
         errors++;
         $display("FAIL sys_entry: epc=%h exl=%b code=%0d want 204/1/8",
                  epc, status_o[1], cause_o[6:2]);
      end
      drive(1, 32'h208, 0, 1, 0, 0, 0, 5'd14);
      checks++;
      if (excptype !== 32'h200 || epc !== 32'h204) begin
         errors++;
         $display("FAIL eret_exc: exc=%h epc=%h want 200/204", excptype, epc);
      end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 5'd14);
      checks++;
      if (status_o !== 32'h0000_8001 || epc !== 32'h204) begin
         errors++;
         $display("FAIL eret_exl: status=%h epc=%h want 8001/204", status_o, epc);
      end
   endtask

   task automatic test_gating();
      drive(0, 32'h500, 1, 0, 0, 0, 0, 5'd12);
      checks++;
      if (excptype !== 32'h0) begin
         errors++;
         $display("FAIL gate_exc: got %h want 0", excptype);
      end
      step();
      checks++;
      if (epc !== 32'h204 || status_o !== 32'h0000_8001) begin
         errors++;
         $display("FAIL gate_state: epc=%h status=%h want 204/8001", epc, status_o);
      end
      drive(0, 0, 0, 0, 1, 5'd11, 32'd20, 5'd9);
      step();
      checks++;
      if (timer_int !== 1'b0 || cause_o[15] !== 1'b0) begin
         errors++;
         $display("FAIL ip7_clear: got %b want 0", timer_int);
      end
      drive(0, 0, 0, 0, 1, 5'd9, 32'd20, 5'd9);
      step();
      drive(0, 0, 0, 0, 1, 5'd11, 32'd30, 5'd9);
      step();
      checks++;
      if (timer_int !== 1'b0) begin
         errors++;
         $display("FAIL clear_wins: got %b want 0", timer_int);
      end
   endtask

   task automatic test_squash();
      drive(0, 0, 0, 0, 1, 5'd12, 32'h0, 5'd14);
      step();
      drive(1, 32'h40, 1, 0, 1, 5'd14, 32'hDEAD, 5'd14);
      checks++;
      if (excptype !== 32'h100) begin
         errors++;
         $display("FAIL squash_exc: got %h want 100", excptype);
      end
      step();
      checks++;
      if (epc !== 32'h44) begin
         errors++;
         $display("FAIL squash_epc: got %h want 44", epc);
      end
      drive(0, 0, 0, 0, 1, 5'd12, 32'h0, 5'd14);
      step();
   endtask

   task automatic test_count_wrap();
      drive(0, 0, 0, 0, 1, 5'd9, 32'hFFFF_FFFF, 5'd9);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 5'd9);
      checks++;
      if (cp0_rdata !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL count_load: got %h want ffffffff", cp0_rdata);
      end
      step();
      checks++;
      if (cp0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL count_wrap: got %h want 0", cp0_rdata);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
`ifdef CP0_RD_BYPASS_EN
      want = 32'h300;
`else
      want = 32'h44;
`endif
      drive(0, 0, 0, 0, 1, 5'd14, 32'h300, 5'd14);
      checks++;
      if (cp0_rdata !== want || epc !== want) begin
         errors++;
         $display("FAIL bypass_same: rdata=%h epc=%h want %h", cp0_rdata, epc, want);
      end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 5'd14);
      checks++;
      if (cp0_rdata !== 32'h300 || epc !== 32'h300) begin
         errors++;
         $display("FAIL bypass_next: rdata=%h epc=%h want 300", cp0_rdata, epc);
      end
   endtask

   task automatic test_random();
      logic [4:0] al [8];
      logic [4:0] wa, ra;
      logic [31:0] wd;
      al = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         wa = al[$urandom_range(0, 7)];
         ra = ($urandom_range(0, 1) == 1) ? al[$urandom_range(0, 7)]
                                           : 5'($urandom_range(0, 31));
         wd = $urandom;
         if (wa == 5'd11) wd = m_count + 32'($urandom_range(1, 6));
         drive($urandom_range(0, 3) != 0, {$urandom, 2'b00} >> 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1, wa, wd, ra);
         checks++;
         if (excptype !== m_exc()) begin
            errors++;
            $display("FAIL rnd_exc[%0d]: got %h want %h", n, excptype, m_exc());
         end
         checks++;
         if (cp0_rdata !== m_rdata()) begin
            errors++;
            $display("FAIL rnd_rdata[%0d]: got %h want %h", n, cp0_rdata, m_rdata());
         end
         checks++;
         if (epc !== m_epc_out()) begin
            errors++;
            $display("FAIL rnd_epc[%0d]: got %h want %h", n, epc, m_epc_out());
         end
         step();
         checks++;
         if (status_o !== m_status() || cause_o !== m_cause() ||
             timer_int !== m_ip7) begin
            errors++;
            $display("FAIL rnd_state[%0d]: got %h/%h/%b want %h/%h/%b", n,
                     status_o, cause_o, timer_int, m_status(), m_cause(), m_ip7);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_tick_div4();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 5'd9);
      step();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 5'd9);
      for (int n = 0; n < 13; n++) begin
         checks++;
         if (r4_rdata !== 32'(n / 4)) begin
            errors++;
            $display("FAIL div4_count[%0d]: got %0d want %0d", n, r4_rdata, n / 4);
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_timer();
      test_syscall_eret();
      test_gating();
      test_squash();
      test_count_wrap();
      test_bypass();
      test_random();
      test_tick_div4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
